// File: rtl/u2_to_zm_serial.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : u2_to_zm_serial
// Purpose  : Bit-serial converter from two's complement (U2) to
//            sign-magnitude (ZM). The operand is captured on a start strobe,
//            then its magnitude is produced LSB-first over M-1 cycles with the
//            "copy up to the first 1, invert the rest" negation rule. The
//            result is presented with a one-cycle valid pulse and a status.
// Ports    : i_clk     - clock, rising edge
//            i_rsn     - asynchronous active-low reset
//            i_start   - conversion request, sampled only while idle
//            i_argA    - U2 operand (M bits, bit M-1 is the sign)
//            o_result  - ZM result, held until the next completion
//            o_status  - 00 non-negative, 01 negative, 10 overflow
//            o_valid   - one-cycle pulse when o_result/o_status update
//            o_busy    - high while a conversion is in progress
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module u2_to_zm_serial #(
   parameter int M = 4
) (
   input  logic         i_clk,
   input  logic         i_rsn,
   input  logic         i_start,
   input  logic [M-1:0] i_argA,
   output logic [M-1:0] o_result,
   output logic [1:0]   o_status,
   output logic         o_valid,
   output logic         o_busy
);

   // Counter indexes the M-1 magnitude bits
   localparam int            CW     = (M > 2) ? $clog2(M-1) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(M-2);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [M-2:0]    opnd_q,  opnd_d;
   logic [M-2:0]    mag_q,   mag_d;
   logic [CW-1:0]   cnt_q,   cnt_d;
   logic            sign_q,  sign_d;
   logic            seen_q,  seen_d;
   logic [M-1:0]    result_q, result_d;
   logic [1:0]      status_q, status_d;
   logic            valid_q,  valid_d;
   logic            w_bit;

   assign w_bit = opnd_q[cnt_q];

   always_comb begin
      state_d  = state_q;
      opnd_d   = opnd_q;
      mag_d    = mag_q;
      cnt_d    = cnt_q;
      sign_d   = sign_q;
      seen_d   = seen_q;
      result_d = result_q;
      status_d = status_q;
      valid_d  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (i_start) begin
               opnd_d  = i_argA[M-2:0];
               sign_d  = i_argA[M-1];
               cnt_d   = '0;
               seen_d  = 1'b0;
               mag_d   = '0;
               state_d = S_SHIFT;
            end
         end

         S_SHIFT: begin
            // Negation: bits up to and including the first 1 pass through,
            // every later bit is inverted. Positive operands pass unchanged.
            mag_d[cnt_q] = sign_q ? (w_bit ^ seen_q) : w_bit;
            seen_d       = seen_q | (sign_q & w_bit);
            cnt_d        = cnt_q + 1'b1;
            if (cnt_q == C_LAST) begin
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            valid_d = 1'b1;
            // A negative operand with no 1 in its magnitude is -2^(M-1),
            // whose magnitude does not fit in M-1 bits.
            if (sign_q && !seen_q) begin
               result_d = '0;
               status_d = 2'b10;
            end else begin
               result_d = {sign_q, mag_q};
               status_d = {1'b0, sign_q};
            end
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rsn) begin
      if (!i_rsn) begin
         state_q  <= S_IDLE;
         opnd_q   <= '0;
         mag_q    <= '0;
         cnt_q    <= '0;
         sign_q   <= 1'b0;
         seen_q   <= 1'b0;
         result_q <= '0;
         status_q <= 2'b00;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         opnd_q   <= opnd_d;
         mag_q    <= mag_d;
         cnt_q    <= cnt_d;
         sign_q   <= sign_d;
         seen_q   <= seen_d;
         result_q <= result_d;
         status_q <= status_d;
         valid_q  <= valid_d;
      end
   end

   assign o_result = result_q;
   assign o_status = status_q;
   assign o_valid  = valid_q;
   assign o_busy   = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_u2_to_zm_serial.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_u2_to_zm_serial
// Purpose  : Self-checking bench for u2_to_zm_serial with M=4 and M=8
//            instances. Expected results are queued when a conversion is
//            driven and compared when the DUT pulses o_valid.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_u2_to_zm_serial;

   typedef struct {
      logic [7:0] res;
      logic [1:0] st;
   } exp_t;

   typedef struct {
      logic [3:0] a;
      logic [3:0] res;
      logic [1:0] st;
   } vec_t;

   logic       clk = 1'b0;
   logic       rsn = 1'b0;

   logic       start4 = 1'b0;
   logic [3:0] a4     = '0;
   logic [3:0] res4;
   logic [1:0] st4;
   logic       valid4, busy4;

   logic       start8 = 1'b0;
   logic [7:0] a8     = '0;
   logic [7:0] res8;
   logic [1:0] st8;
   logic       valid8, busy8;

   int   nchecks = 0;
   int   nfail   = 0;
   exp_t q4[$];
   exp_t q8[$];

   always #5 clk = ~clk;

   u2_to_zm_serial #(.M(4)) dut4 (
      .i_clk(clk), .i_rsn(rsn), .i_start(start4), .i_argA(a4),
      .o_result(res4), .o_status(st4), .o_valid(valid4), .o_busy(busy4)
   );

   u2_to_zm_serial #(.M(8)) dut8 (
      .i_clk(clk), .i_rsn(rsn), .i_start(start8), .i_argA(a8),
      .o_result(res8), .o_status(st8), .o_valid(valid8), .o_busy(busy8)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Arithmetic reference: sign-magnitude of an M-bit signed value
   function automatic exp_t model(input int v, input int m);
      exp_t e;
      if (v == -(1 << (m-1))) begin
         e.res = 8'h00; e.st = 2'b10;
      end else if (v < 0) begin
         e.res = 8'((1 << (m-1)) | (-v)); e.st = 2'b01;
      end else begin
         e.res = 8'(v); e.st = 2'b00;
      end
      return e;
   endfunction

   // Scoreboard monitors
   always @(negedge clk) begin
      if (valid4) begin
         if (q4.size() == 0) begin
            chk("unexpected_valid4", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q4.pop_front();
            chk("result4", {28'd0, res4}, {28'd0, e.res[3:0]});
            chk("status4", {30'd0, st4}, {30'd0, e.st});
         end
      end
      if (valid8) begin
         if (q8.size() == 0) begin
            chk("unexpected_valid8", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q8.pop_front();
            chk("result8", {24'd0, res8}, {24'd0, e.res});
            chk("status8", {30'd0, st8}, {30'd0, e.st});
         end
      end
   end

   // One conversion, checking latency, busy duration and output hold
   task automatic do_conv(input bit w8, input logic [7:0] a, input exp_t e);
      int lat;
      int bcnt;
      bit v;
      @(negedge clk);
      if (w8) begin
         start8 = 1'b1; a8 = a; q8.push_back(e);
      end else begin
         start4 = 1'b1; a4 = a[3:0]; q4.push_back(e);
      end
      @(negedge clk);
      start4 = 1'b0; start8 = 1'b0;
      a4 = ~a4; a8 = ~a8;      // operand is don't-care after the accept edge
      lat  = 0;
      bcnt = 0;
      forever begin
         v = w8 ? valid8 : valid4;
         if (w8 ? busy8 : busy4) bcnt++;
         if (v) break;
         if (lat > 20) begin
            chk("valid_timeout", 32'd0, 32'd1);
            break;
         end
         @(negedge clk);
         lat++;
      end
      chk(w8 ? "latency8" : "latency4", lat, w8 ? 8 : 4);
      chk(w8 ? "busy_cycles8" : "busy_cycles4", bcnt, w8 ? 8 : 4);
      if (!w8) begin
         @(negedge clk);
         chk("hold_result4", {28'd0, res4}, {28'd0, e.res[3:0]});
         chk("valid4_one_cycle", {31'd0, valid4}, 32'd0);
      end
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((q4.size() != 0 || q8.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("drain_empty", q4.size() + q8.size(), 0);
   endtask

   vec_t vecs[9];

   initial begin
      exp_t e;
      vecs[0] = '{4'b0101, 4'b0101, 2'b00};
      vecs[1] = '{4'b1101, 4'b1011, 2'b01};
      vecs[2] = '{4'b1111, 4'b1001, 2'b01};
      vecs[3] = '{4'b1001, 4'b1111, 2'b01};
      vecs[4] = '{4'b1000, 4'b0000, 2'b10};
      vecs[5] = '{4'b0000, 4'b0000, 2'b00};
      vecs[6] = '{4'b0111, 4'b0111, 2'b00};
      vecs[7] = '{4'b1110, 4'b1010, 2'b01};
      vecs[8] = '{4'b1100, 4'b1100, 2'b01};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_result4", {28'd0, res4}, 32'd0);
      chk("rst_status4", {30'd0, st4}, 32'd0);
      chk("rst_valid4", {31'd0, valid4}, 32'd0);
      chk("rst_busy4", {31'd0, busy4}, 32'd0);
      chk("rst_result8", {24'd0, res8}, 32'd0);
      rsn = 1'b1;

      // Table-driven M=4 vectors
      for (int i = 0; i < 9; i++) begin
         e.res = {4'd0, vecs[i].res};
         e.st  = vecs[i].st;
         do_conv(1'b0, {4'd0, vecs[i].a}, e);
      end
      drain(10);

      // Start held high with a changing operand: accepts every 5 cycles
      @(negedge clk);
      for (int c = 0; c < 20; c++) begin
         logic [3:0] r;
         r = 4'($urandom_range(0, 15));
         start4 = 1'b1;
         a4 = r;
         if (c % 5 == 0) q4.push_back(model((r >= 8) ? int'(r) - 16 : int'(r), 4));
         @(negedge clk);
      end
      start4 = 1'b0;
      drain(20);

      // Leave a known non-zero result, then reset mid-SHIFT (counter = 1)
      e.res = 8'h0B; e.st = 2'b01;
      do_conv(1'b0, 8'h0D, e);
      @(negedge clk);
      start4 = 1'b1; a4 = 4'b0101;
      @(negedge clk);              // accept edge passed
      start4 = 1'b0;
      @(negedge clk);              // one SHIFT edge processed
      rsn = 1'b0;
      #1;
      chk("midrst_result4", {28'd0, res4}, 32'd0);
      chk("midrst_status4", {30'd0, st4}, 32'd0);
      chk("midrst_busy4", {31'd0, busy4}, 32'd0);
      chk("midrst_valid4", {31'd0, valid4}, 32'd0);
      repeat (2) @(negedge clk);
      rsn = 1'b1;
      repeat (6) @(negedge clk);   // any stray valid is caught by the monitor
      e.res = 8'h09; e.st = 2'b01;
      do_conv(1'b0, 8'h0F, e);

      // Exhaustive M=8 sweep
      for (int v = -128; v < 128; v++) begin
         do_conv(1'b1, 8'(v), model(v, 8));
      end
      drain(20);

      $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
